// File: rtl/slice_cfg_pkg.sv
// Shared FSM state type, image bit-map constants and size derivations for the
// slice configuration loader.
package slice_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } cfg_state_e;

    // Stream bit 0 drives the carry-chain enable; LUT bits follow from bit 1.
    localparam int USE_CC_BIT     = 0;
    localparam int LUT_BIT_OFFSET = 1;

    function automatic int calc_img_bits(input int num_luts, input int cfg_size);
        return num_luts * 2 * cfg_size + 1;
    endfunction

    function automatic int calc_num_beats(input int img_bits, input int cfg_w);
        return (img_bits + cfg_w - 1) / cfg_w;
    endfunction

endpackage

// File: rtl/slice_cfg_beat_assembler.sv
// Staging register, beat counter and (SLICE_CFG_CRC_EN) XOR checksum for one
// configuration image; pad lanes of the last beat are never stored.
module slice_cfg_beat_assembler #(
    parameter int CFG_W     = 8,
    parameter int IMG_BITS  = 137,
    parameter int NUM_BEATS = 18,
    parameter int CNT_W     = $clog2(NUM_BEATS + 1)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear_i,
    input  logic                beat_we_i,
    input  logic [CFG_W-1:0]    beat_i,
    output logic [IMG_BITS-1:0] stage_o,
`ifdef SLICE_CFG_CRC_EN
    output logic                chk_done_o,
    output logic                chk_ok_o,
`endif
    output logic                full_o
);

    logic [IMG_BITS-1:0] stage_q, stage_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                full;

    assign full    = (cnt_q == CNT_W'(NUM_BEATS));
    assign full_o  = full;
    assign stage_o = stage_q;

`ifdef SLICE_CFG_CRC_EN
    logic [CFG_W-1:0] xor_q, xor_d;
    logic             chk_done_q, chk_done_d;
    logic             chk_ok_q, chk_ok_d;

    assign chk_done_o = chk_done_q;
    assign chk_ok_o   = chk_ok_q;
`endif

    always_comb begin
        stage_d = stage_q;
        cnt_d   = cnt_q;
`ifdef SLICE_CFG_CRC_EN
        xor_d      = xor_q;
        chk_done_d = chk_done_q;
        chk_ok_d   = chk_ok_q;
`endif
        if (clear_i) begin
            cnt_d = '0;
`ifdef SLICE_CFG_CRC_EN
            xor_d      = '0;
            chk_done_d = 1'b0;
            chk_ok_d   = 1'b0;
`endif
        end else if (beat_we_i && !full) begin
            for (int b = 0; b < NUM_BEATS; b++) begin
                if (cnt_q == CNT_W'(b)) begin
                    for (int l = 0; l < CFG_W; l++) begin
                        if (b * CFG_W + l < IMG_BITS) begin
                            stage_d[b * CFG_W + l] = beat_i[l];
                        end
                    end
                end
            end
            cnt_d = cnt_q + CNT_W'(1);
`ifdef SLICE_CFG_CRC_EN
            xor_d = xor_q ^ beat_i;
`endif
        end
`ifdef SLICE_CFG_CRC_EN
        // The beat after a full image is the checksum, covering pad lanes as sent.
        else if (beat_we_i && full) begin
            chk_done_d = 1'b1;
            chk_ok_d   = (beat_i == xor_q);
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stage_q <= '0;
            cnt_q   <= '0;
`ifdef SLICE_CFG_CRC_EN
            xor_q      <= '0;
            chk_done_q <= 1'b0;
            chk_ok_q   <= 1'b0;
`endif
        end else begin
            stage_q <= stage_d;
            cnt_q   <= cnt_d;
`ifdef SLICE_CFG_CRC_EN
            xor_q      <= xor_d;
            chk_done_q <= chk_done_d;
            chk_ok_q   <= chk_ok_d;
`endif
        end
    end

endmodule

// File: rtl/slice_config_loader.sv
// Beat-serial config loader for one logic slice: assembles an image, then commits
// it with a one-cycle cen strobe. Define SLICE_CFG_CRC_EN for the XOR checksum beat.
module slice_config_loader
    import slice_cfg_pkg::*;
#(
    parameter int S_XX_BASE = 4,
    parameter int CFG_SIZE  = 2**S_XX_BASE + 1,
    parameter int NUM_LUTS  = 4,
    parameter int CFG_W     = 8
) (
    input  logic                           cclk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [CFG_W-1:0]               cfg_data,
    input  logic                           cfg_valid,
    output logic                           cfg_ready,
    output logic [NUM_LUTS*2*CFG_SIZE-1:0] luts_config_out,
    output logic                           config_use_cc,
    output logic                           cen,
    output logic                           busy,
    output logic                           done,
    output logic                           err,
    output logic [1:0]                     dbg_state_o
);

    localparam int IMG_BITS  = calc_img_bits(NUM_LUTS, CFG_SIZE);
    localparam int NUM_BEATS = calc_num_beats(IMG_BITS, CFG_W);
    localparam int LUT_W     = NUM_LUTS * 2 * CFG_SIZE;
    localparam int CNT_W     = $clog2(NUM_BEATS + 1);

    cfg_state_e          state_q, state_d;
    logic [LUT_W-1:0]    luts_q, luts_d;
    logic                use_cc_q, use_cc_d;
    logic                done_q, done_d;
    logic [IMG_BITS-1:0] stage;
    logic                full;
    logic                clear;
    logic                beat_we;

    // Valid/ready: a beat transfers on a rising cclk edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is only ever high in LOAD.
    assign beat_we = cfg_valid & cfg_ready;

`ifdef SLICE_CFG_CRC_EN
    logic chk_done, chk_ok;
    logic err_q, err_d;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    slice_cfg_beat_assembler #(
        .CFG_W     (CFG_W),
        .IMG_BITS  (IMG_BITS),
        .NUM_BEATS (NUM_BEATS),
        .CNT_W     (CNT_W)
    ) u_assembler (
        .clk_i      (cclk),
        .rst_i      (rst),
        .clear_i    (clear),
        .beat_we_i  (beat_we),
        .beat_i     (cfg_data),
        .stage_o    (stage),
`ifdef SLICE_CFG_CRC_EN
        .chk_done_o (chk_done),
        .chk_ok_o   (chk_ok),
`endif
        .full_o     (full)
    );

    always_comb begin
        state_d   = state_q;
        luts_d    = luts_q;
        use_cc_d  = use_cc_q;
        done_d    = done_q;
`ifdef SLICE_CFG_CRC_EN
        err_d     = err_q;
`endif
        cfg_ready = 1'b0;
        cen       = 1'b0;
        clear     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clear   = 1'b1;
                    done_d  = 1'b0;
`ifdef SLICE_CFG_CRC_EN
                    err_d   = 1'b0;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: begin
`ifdef SLICE_CFG_CRC_EN
                cfg_ready = !chk_done;
                if (full && chk_done) begin
                    if (chk_ok) begin
                        luts_d   = stage[IMG_BITS-1:LUT_BIT_OFFSET];
                        use_cc_d = stage[USE_CC_BIT];
                        state_d  = COMMIT;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
`else
                cfg_ready = !full;
                // Outputs load from the completed staging image on COMMIT entry.
                if (full) begin
                    luts_d   = stage[IMG_BITS-1:LUT_BIT_OFFSET];
                    use_cc_d = stage[USE_CC_BIT];
                    state_d  = COMMIT;
                end
`endif
            end
            COMMIT: begin
                cen     = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q  <= IDLE;
            luts_q   <= '0;
            use_cc_q <= 1'b0;
            done_q   <= 1'b0;
`ifdef SLICE_CFG_CRC_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            luts_q   <= luts_d;
            use_cc_q <= use_cc_d;
            done_q   <= done_d;
`ifdef SLICE_CFG_CRC_EN
            err_q    <= err_d;
`endif
        end
    end

    assign luts_config_out = luts_q;
    assign config_use_cc   = use_cc_q;
    assign busy            = (state_q != IDLE);
    assign done            = done_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_slice_config_loader.sv
// Directed bench for slice_config_loader: default instance plus a NUM_LUTS=2,
// CFG_W=16 instance, checked with immediate assertions against hand-built images.
module tb_slice_config_loader;

    logic cclk = 1'b0;
    always #5 cclk = ~cclk;

    logic         rst, start, cfg_valid;
    logic [7:0]   cfg_data;
    logic         cfg_ready, config_use_cc, cen, busy, done, err;
    logic [135:0] luts;
    logic [1:0]   dbg_state;

    logic         start2, cfg_valid2;
    logic [15:0]  cfg_data2;
    logic         cfg_ready2, use_cc2, cen2, busy2, done2, err2;
    logic [67:0]  luts2;
    logic [1:0]   dbg_state2;

    slice_config_loader dut (
        .cclk(cclk), .rst(rst), .start(start), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .luts_config_out(luts), .config_use_cc(config_use_cc),
        .cen(cen), .busy(busy), .done(done), .err(err), .dbg_state_o(dbg_state)
    );

    slice_config_loader #(.NUM_LUTS(2), .CFG_W(16)) dut2 (
        .cclk(cclk), .rst(rst), .start(start2), .cfg_data(cfg_data2), .cfg_valid(cfg_valid2),
        .cfg_ready(cfg_ready2), .luts_config_out(luts2), .config_use_cc(use_cc2),
        .cen(cen2), .busy(busy2), .done(done2), .err(err2), .dbg_state_o(dbg_state2)
    );

    int errors = 0;
    int checks = 0;
    int cen_cnt = 0;
    int cen2_cnt = 0;
    logic [7:0]   img1 [18];
    logic [15:0]  img2 [5];
    logic [135:0] last_luts = '0;

    always @(posedge cclk) begin
        if (cen === 1'b1) cen_cnt++;
        if (cen2 === 1'b1) cen2_cnt++;
    end

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [136:0] model_img1();
        logic [136:0] r;
        for (int k = 0; k < 137; k++) r[k] = img1[k / 8][k % 8];
        return r;
    endfunction

    task automatic send1(input logic [7:0] d, input int gap);
        for (int g = 0; g < gap; g++) begin
            cfg_valid = 1'b0;
            @(posedge cclk); #1;
            check("ready_in_gap", cfg_ready, 1);
        end
        cfg_data = d;
        cfg_valid = 1'b1;
        for (int t = 0; t < 20 && cfg_ready !== 1'b1; t++) begin
            @(posedge cclk); #1;
        end
        check("ready_at_beat", cfg_ready, 1);
        @(posedge cclk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic send_chk1(input int gap, input logic [7:0] flip);
        logic [7:0] x;
        x = '0;
        for (int b = 0; b < 18; b++) x ^= img1[b];
        send1(x ^ flip, gap);
    endtask

    task automatic start1();
        start = 1'b1;
        @(posedge cclk); #1;
        start = 1'b0;
    endtask

    // Entered one time unit after the last handshake edge.
    task automatic commit_check1(input string tag, input logic start_in_commit);
        logic [136:0] exp_img;
        int c0;
        exp_img = model_img1();
        c0 = cen_cnt;
        check({tag, "_cen_pre"}, cen, 0);
        check({tag, "_hold"}, luts, last_luts);
        @(posedge cclk); #1;
        check({tag, "_cen"}, cen, 1);
        check({tag, "_luts"}, luts, exp_img[136:1]);
        check({tag, "_use_cc"}, config_use_cc, exp_img[0]);
        check({tag, "_state_commit"}, dbg_state, 2);
        start = start_in_commit;
        @(posedge cclk); #1;
        start = 1'b0;
        check({tag, "_cen_post"}, cen, 0);
        check({tag, "_done"}, done, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_state_idle"}, dbg_state, 0);
        check({tag, "_one_cen"}, cen_cnt - c0, 1);
        last_luts = exp_img[136:1];
    endtask

    task automatic send2(input logic [15:0] d);
        cfg_data2 = d;
        cfg_valid2 = 1'b1;
        for (int t = 0; t < 20 && cfg_ready2 !== 1'b1; t++) begin
            @(posedge cclk); #1;
        end
        check("ready2_at_beat", cfg_ready2, 1);
        @(posedge cclk); #1;
        cfg_valid2 = 1'b0;
    endtask

    task automatic load2(input string tag);
        logic [15:0] x;
        int c0;
        c0 = cen2_cnt;
        x = '0;
        start2 = 1'b1;
        @(posedge cclk); #1;
        start2 = 1'b0;
        for (int b = 0; b < 5; b++) begin
            send2(img2[b]);
            x ^= img2[b];
        end
`ifdef SLICE_CFG_CRC_EN
        send2(x);
`endif
        @(posedge cclk); #1;
        check({tag, "_cen"}, cen2, 1);
        check({tag, "_luts"}, luts2, {5'h15, 16'hC3C3, 16'h0F0F, 16'h1234, 15'h52D2});
        check({tag, "_use_cc"}, use_cc2, 1);
        @(posedge cclk); #1;
        check({tag, "_done"}, done2, 1);
        check({tag, "_one_cen"}, cen2_cnt - c0, 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        start2 = 1'b0; cfg_valid2 = 1'b0; cfg_data2 = '0;
        repeat (3) @(posedge cclk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 0);
        check("rst_luts", luts, 0);
        check("rst_use_cc", config_use_cc, 0);
        check("rst_cen", cen, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_state", dbg_state, 0);
        check("rst_luts2", luts2, 0);
        rst = 1'b0;
        @(posedge cclk); #1;

        // Back-to-back load, beat b = b+1.
        for (int b = 0; b < 18; b++) img1[b] = 8'(b + 1);
        check("t1_idle_ready", cfg_ready, 0);
        start1();
        check("t1_state_load", dbg_state, 1);
        for (int b = 0; b < 18; b++) send1(img1[b], 0);
`ifdef SLICE_CFG_CRC_EN
        send_chk1(0, 8'h00);
`endif
        commit_check1("t1", 1'b0);
        check("t1_hand_use_cc", config_use_cc, 1);
        check("t1_hand_lo", luts[6:0], 7'h00);
        check("t1_hand_beat1", luts[14:7], 8'h02);
        check("t1_hand_beat16", luts[134:127], 8'h11);

        // Same stream with valid low every other cycle.
        start1();
        for (int b = 0; b < 18; b++) send1(img1[b], 1);
`ifdef SLICE_CFG_CRC_EN
        send_chk1(1, 8'h00);
`endif
        commit_check1("t2", 1'b0);

        // Reset after beat 9 aborts the load.
        begin
            int c0;
            c0 = cen_cnt;
            start1();
            for (int b = 0; b < 10; b++) send1(img1[b], 0);
            check("t3_hold_midload", luts, last_luts);
            rst = 1'b1;
            @(posedge cclk); #1;
            rst = 1'b0;
            check("t3_busy", busy, 0);
            check("t3_ready", cfg_ready, 0);
            check("t3_luts", luts, 0);
            check("t3_use_cc", config_use_cc, 0);
            check("t3_done", done, 0);
            repeat (3) @(posedge cclk);
            #1;
            check("t3_no_cen", cen_cnt - c0, 0);
            last_luts = '0;
        end
        for (int b = 0; b < 18; b++) img1[b] = 8'(b * 37 + 5);
        start1();
        for (int b = 0; b < 18; b++) send1(img1[b], 0);
`ifdef SLICE_CFG_CRC_EN
        send_chk1(0, 8'h00);
`endif
        commit_check1("t3_reload", 1'b0);
        check("t3_hand_lo", luts[6:0], 7'h02);

        // Start with valid high in IDLE, start pulses during LOAD and COMMIT.
        for (int b = 0; b < 18; b++) img1[b] = 8'(b * 13) ^ 8'h5A;
        cfg_data = img1[0];
        cfg_valid = 1'b1;
        start = 1'b1;
        @(posedge cclk); #1;
        start = 1'b0;
        check("t4_state_load", dbg_state, 1);
        for (int b = 0; b < 18; b++) begin
            send1(img1[b], 0);
            if (b == 5) begin
                start1();
                check("t4_still_load", dbg_state, 1);
            end
        end
`ifdef SLICE_CFG_CRC_EN
        send_chk1(0, 8'h00);
`endif
        commit_check1("t4", 1'b1);
        check("t4_hand_use_cc", config_use_cc, 0);
        check("t4_hand_lo", luts[6:0], 7'h2D);

`ifdef SLICE_CFG_CRC_EN
        // All-ones image: good checksum commits, bad checksum is rejected.
        for (int b = 0; b < 18; b++) img1[b] = 8'hFF;
        start1();
        for (int b = 0; b < 18; b++) send1(img1[b], 0);
        send_chk1(0, 8'h00);
        commit_check1("crc_ok", 1'b0);
        check("crc_ok_err", err, 0);
        begin
            int c0;
            c0 = cen_cnt;
            start1();
            check("crc_done_cleared", done, 0);
            for (int b = 0; b < 18; b++) send1(img1[b], 0);
            send_chk1(0, 8'h01);
            repeat (3) @(posedge cclk);
            #1;
            check("crc_bad_err", err, 1);
            check("crc_bad_done", done, 0);
            check("crc_bad_no_cen", cen_cnt - c0, 0);
            check("crc_bad_luts", luts, last_luts);
            check("crc_bad_state", dbg_state, 0);
            start1();
            check("crc_err_cleared", err, 0);
            rst = 1'b1;
            @(posedge cclk); #1;
            rst = 1'b0;
        end
`endif

        // Narrow instance: 69-bit image in 5 beats, pad lanes set then clear.
        img2[0] = 16'hA5A5;
        img2[1] = 16'h1234;
        img2[2] = 16'h0F0F;
        img2[3] = 16'hC3C3;
        img2[4] = 16'hFFF5;
        load2("n_pad1");
        img2[4] = 16'h0015;
        load2("n_pad0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
